// File: rtl/usb_token_rx_pkg.sv
// Shared types for the USB token receive path: PID encoding, token record,
// CRC5 constants and the token decoder state encoding.
package usb_token_rx_pkg;

   localparam logic       USB_FULL_SPEED = 1'b1;
   localparam logic [4:0] CRC5_INIT      = 5'b11111;
   localparam logic [4:0] CRC5_POLY      = 5'b00101;
   localparam logic [4:0] CRC5_RESIDUAL  = 5'b01100;

   typedef enum logic [3:0] {
      PID_RESERVED = 4'b0000,
      PID_OUT      = 4'b0001,
      PID_ACK      = 4'b0010,
      PID_DATA0    = 4'b0011,
      PID_PING     = 4'b0100,
      PID_SOF      = 4'b0101,
      PID_NYET     = 4'b0110,
      PID_DATA2    = 4'b0111,
      PID_SPLIT    = 4'b1000,
      PID_IN       = 4'b1001,
      PID_NAK      = 4'b1010,
      PID_DATA1    = 4'b1011,
      PID_PRE      = 4'b1100,
      PID_SETUP    = 4'b1101,
      PID_STALL    = 4'b1110,
      PID_MDATA    = 4'b1111
   } pid_t;

   typedef struct packed {
      pid_t       pid;
      logic [6:0] addr;
      logic [3:0] endp;
      logic [4:0] crc5;
   } token_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PID  = 3'd1,
      ST_TOK1 = 3'd2,
      ST_TOK2 = 3'd3,
      ST_TEOP = 3'd4,
      ST_SKIP = 3'd5
   } tok_state_t;

   // Token PIDs (OUT/IN/SOF/SETUP) all end in 2'b01.
   function automatic logic pid_is_token(input logic [3:0] p);
      return (p[1:0] == 2'b01);
   endfunction

endpackage

// File: rtl/usb_crc5.sv
// Combinational CRC5 update over one byte, bits taken LSB first (wire order).
module usb_crc5
   import usb_token_rx_pkg::*;
(
   input  logic [4:0] crc_in,
   input  logic [7:0] data,
   output logic [4:0] crc_out
);

   logic [4:0] crc_v;

   // Unrolled serial LFSR, one step per data bit.
   always_comb begin
      crc_v = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (crc_v[4] ^ data[i]) begin
            crc_v = {crc_v[3:0], 1'b0} ^ CRC5_POLY;
         end else begin
            crc_v = {crc_v[3:0], 1'b0};
         end
      end
      crc_out = crc_v;
   end

endmodule

// File: rtl/usb_token_rx.sv
// Packet-level receive stage: decodes the PID byte and, for token packets,
// assembles and checks addr/endp/crc5 before handing the token to the SIE.
module usb_token_rx
   import usb_token_rx_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_active,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        rx_error,
   input  logic [6:0]  dev_addr,
   output pid_t        pid,
   output logic        pid_valid,
   output token_t      token,
   output logic [10:0] frame_no,
   output logic        token_done,
   output logic        pid_err,
   output logic        crc5_err
);

   tok_state_t  state_q, state_d;
   logic        rx_active_q;
   logic [7:0]  b1_q, b1_d, b2_q, b2_d;
   logic [4:0]  crc_q, crc_d, crc_next;
   logic        len_err_q, len_err_d;
   pid_t        pid_q, pid_d;
   token_t      token_q, token_d;
   logic [10:0] frame_no_q, frame_no_d;
   logic        pid_valid_q, pid_valid_d;
   logic        token_done_q, token_done_d;
   logic        pid_err_q, pid_err_d;
   logic        crc5_err_q, crc5_err_d;
   logic        rx_active_rise;

   assign rx_active_rise = rx_active & ~rx_active_q;

   usb_crc5 u_crc5 (
      .crc_in  (crc_q),
      .data    (rx_data),
      .crc_out (crc_next)
   );

   always_comb begin
      state_d      = state_q;
      b1_d         = b1_q;
      b2_d         = b2_q;
      crc_d        = crc_q;
      len_err_d    = len_err_q;
      pid_d        = pid_q;
      token_d      = token_q;
      frame_no_d   = frame_no_q;
      pid_valid_d  = 1'b0;
      token_done_d = 1'b0;
      pid_err_d    = 1'b0;
      crc5_err_d   = 1'b0;

      // A new SYNC without a preceding EOP discards whatever was in flight.
      if (state_q != ST_IDLE && rx_active_rise) begin
         state_d   = ST_PID;
         len_err_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               len_err_d = 1'b0;
               if (rx_active) state_d = ST_PID;
               else           state_d = ST_IDLE;
            end
            ST_PID: begin
               if (rx_error) begin
                  state_d = ST_SKIP;
               end else if (!rx_active) begin
                  state_d = ST_IDLE;
               end else if (rx_valid) begin
                  if (rx_data[7:4] != ~rx_data[3:0]) begin
                     pid_err_d = 1'b1;
                     state_d   = ST_SKIP;
                  end else if (pid_is_token(rx_data[3:0])) begin
                     pid_d   = pid_t'(rx_data[3:0]);
                     crc_d   = CRC5_INIT;
                     state_d = ST_TOK1;
                  end else begin
                     pid_d       = pid_t'(rx_data[3:0]);
                     pid_valid_d = 1'b1;
                     state_d     = ST_SKIP;
                  end
               end else begin
                  state_d = ST_PID;
               end
            end
            ST_TOK1: begin
               if (rx_error) begin
                  state_d = ST_SKIP;
               end else if (!rx_active) begin
                  crc5_err_d = 1'b1;
                  state_d    = ST_IDLE;
               end else if (rx_valid) begin
                  b1_d    = rx_data;
                  crc_d   = crc_next;
                  state_d = ST_TOK2;
               end else begin
                  state_d = ST_TOK1;
               end
            end
            ST_TOK2: begin
               if (rx_error) begin
                  state_d = ST_SKIP;
               end else if (!rx_active) begin
                  crc5_err_d = 1'b1;
                  state_d    = ST_IDLE;
               end else if (rx_valid) begin
                  b2_d    = rx_data;
                  crc_d   = crc_next;
                  state_d = ST_TEOP;
               end else begin
                  state_d = ST_TOK2;
               end
            end
            ST_TEOP: begin
               if (rx_error) begin
                  state_d = ST_SKIP;
               end else if (!rx_active) begin
                  state_d = ST_IDLE;
                  // Shadow bytes only reach the outputs once the whole packet checks out.
                  if (crc_q != CRC5_RESIDUAL) begin
                     crc5_err_d = 1'b1;
                  end else if (pid_q == PID_SOF) begin
                     frame_no_d   = {b2_q[2:0], b1_q};
                     token_done_d = 1'b1;
                  end else if (b1_q[6:0] == dev_addr) begin
                     token_d.pid  = pid_q;
                     token_d.addr = b1_q[6:0];
                     token_d.endp = {b2_q[2:0], b1_q[7]};
                     token_d.crc5 = b2_q[7:3];
                     token_done_d = 1'b1;
                  end else begin
                     token_done_d = 1'b0;
                  end
               end else if (rx_valid) begin
                  len_err_d = 1'b1;
                  state_d   = ST_SKIP;
               end else begin
                  state_d = ST_TEOP;
               end
            end
            ST_SKIP: begin
               if (rx_error) begin
                  len_err_d = 1'b0;
               end else if (!rx_active) begin
                  crc5_err_d = len_err_q;
                  len_err_d  = 1'b0;
                  state_d    = ST_IDLE;
               end else begin
                  state_d = ST_SKIP;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rx_active_q  <= 1'b0;
         b1_q         <= 8'd0;
         b2_q         <= 8'd0;
         crc_q        <= CRC5_INIT;
         len_err_q    <= 1'b0;
         pid_q        <= PID_RESERVED;
         token_q      <= '0;
         frame_no_q   <= 11'd0;
         pid_valid_q  <= 1'b0;
         token_done_q <= 1'b0;
         pid_err_q    <= 1'b0;
         crc5_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         rx_active_q  <= rx_active;
         b1_q         <= b1_d;
         b2_q         <= b2_d;
         crc_q        <= crc_d;
         len_err_q    <= len_err_d;
         pid_q        <= pid_d;
         token_q      <= token_d;
         frame_no_q   <= frame_no_d;
         pid_valid_q  <= pid_valid_d;
         token_done_q <= token_done_d;
         pid_err_q    <= pid_err_d;
         crc5_err_q   <= crc5_err_d;
      end
   end

   assign pid        = pid_q;
   assign pid_valid  = pid_valid_q;
   assign token      = token_q;
   assign frame_no   = frame_no_q;
   assign token_done = token_done_q;
   assign pid_err    = pid_err_q;
   assign crc5_err   = crc5_err_q;

endmodule

// File: tb/tb_usb_token_rx.sv
// Directed bench for usb_token_rx: hand-built token/handshake packets with
// hand-computed CRC5 bytes and expected responses.
module tb_usb_token_rx;
   import usb_token_rx_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_active;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_error;
   logic [6:0]  dev_addr;
   pid_t        pid;
   logic        pid_valid;
   token_t      token;
   logic [10:0] frame_no;
   logic        token_done;
   logic        pid_err;
   logic        crc5_err;

   int n_checks = 0;
   int n_errors = 0;
   int c_pv = 0, c_td = 0, c_pe = 0, c_ce = 0;
   int s_pv = 0, s_td = 0, s_pe = 0, s_ce = 0;

   token_t      exp_tok;
   logic [3:0]  snap;

   usb_token_rx dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_active  (rx_active),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_error   (rx_error),
      .dev_addr   (dev_addr),
      .pid        (pid),
      .pid_valid  (pid_valid),
      .token      (token),
      .frame_no   (frame_no),
      .token_done (token_done),
      .pid_err    (pid_err),
      .crc5_err   (crc5_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pid_valid)  c_pv = c_pv + 1;
      if (token_done) c_td = c_td + 1;
      if (pid_err)    c_pe = c_pe + 1;
      if (crc5_err)   c_ce = c_ce + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pkt_start;
      s_pv = c_pv; s_td = c_td; s_pe = c_pe; s_ce = c_ce;
      rx_active = 1'b1;
      tick; tick;
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick;
      rx_valid = 1'b0;
      tick;
   endtask

   // Snapshot {pid_valid, token_done, pid_err, crc5_err} one clock after EOP.
   task automatic pkt_end(output logic [3:0] s);
      rx_active = 1'b0;
      tick;
      s = {pid_valid, token_done, pid_err, crc5_err};
      tick; tick; tick;
   endtask

   // Pulse counts over the packet, one nibble each: pv, td, pe, ce.
   task automatic check_counts(input string tag, input logic [15:0] exp);
      check_eq(tag, 32'({4'(c_pv - s_pv), 4'(c_td - s_td), 4'(c_pe - s_pe), 4'(c_ce - s_ce)}), 32'(exp));
   endtask

   initial begin
      rst_n = 1'b0; rx_active = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      rx_error = 1'b0; dev_addr = 7'd0;
      tick; tick; tick;
      check_eq("reset_pid", 32'(pid), 32'(PID_RESERVED));
      check_eq("reset_token", 32'(token), 32'd0);
      check_eq("reset_frame", 32'(frame_no), 32'd0);
      check_eq("reset_pulses", 32'({pid_valid, token_done, pid_err, crc5_err}), 32'd0);
      rst_n = 1'b1;
      tick; tick;

      // SETUP addr 0 endp 0
      dev_addr = 7'd0;
      pkt_start; send(8'h2D); send(8'h00); send(8'h10); pkt_end(snap);
      check_eq("setup_eop_pulse", 32'(snap), 32'h4);
      check_counts("setup_counts", 16'h0100);
      exp_tok = '{pid: PID_SETUP, addr: 7'd0, endp: 4'd0, crc5: 5'h02};
      check_eq("setup_token", 32'(token), 32'(exp_tok));
      check_eq("setup_pid", 32'(pid), 32'(PID_SETUP));

      // OUT addr 5 endp 1 to matching device
      dev_addr = 7'd5;
      pkt_start; send(8'hE1); send(8'h85); send(8'h60); pkt_end(snap);
      check_eq("out_eop_pulse", 32'(snap), 32'h4);
      exp_tok = '{pid: PID_OUT, addr: 7'd5, endp: 4'd1, crc5: 5'h0C};
      check_eq("out_token", 32'(token), 32'(exp_tok));

      // SOF frame 0 is accepted regardless of address, token untouched
      pkt_start; send(8'hA5); send(8'h00); send(8'h10); pkt_end(snap);
      check_eq("sof0_eop_pulse", 32'(snap), 32'h4);
      check_eq("sof0_frame", 32'(frame_no), 32'h000);
      check_eq("sof0_token_held", 32'(token), 32'(exp_tok));

      pkt_start; send(8'hA5); send(8'h85); send(8'h60); pkt_end(snap);
      check_eq("sof85_eop_pulse", 32'(snap), 32'h4);
      check_eq("sof85_frame", 32'(frame_no), 32'h085);

      // Good SETUP to another device: silent
      pkt_start; send(8'h2D); send(8'h00); send(8'h10); pkt_end(snap);
      check_counts("addr_mismatch_counts", 16'h0000);
      check_eq("addr_mismatch_token", 32'(token), 32'(exp_tok));

      // Corrupt CRC byte
      dev_addr = 7'd0;
      pkt_start; send(8'h2D); send(8'h00); send(8'h11); pkt_end(snap);
      check_eq("badcrc_eop_pulse", 32'(snap), 32'h1);
      check_counts("badcrc_counts", 16'h0001);
      check_eq("badcrc_token", 32'(token), 32'(exp_tok));

      // PID check failure
      pkt_start; send(8'h2E); send(8'h00); send(8'h10); pkt_end(snap);
      check_counts("pid_err_counts", 16'h0010);
      check_eq("pid_err_pid_held", 32'(pid), 32'(PID_SETUP));

      // ACK handshake
      pkt_start; send(8'hD2); pkt_end(snap);
      check_counts("ack_counts", 16'h1000);
      check_eq("ack_pid", 32'(pid), 32'(PID_ACK));

      // Byte strobes outside a packet are ignored
      s_pv = c_pv; s_td = c_td; s_pe = c_pe; s_ce = c_ce;
      send(8'h2D); send(8'h00); send(8'h10); tick; tick;
      check_counts("idle_valid_counts", 16'h0000);

      // Short token
      pkt_start; send(8'h2D); send(8'h00); pkt_end(snap);
      check_eq("short_eop_pulse", 32'(snap), 32'h1);
      check_counts("short_counts", 16'h0001);

      // Long token
      pkt_start; send(8'h2D); send(8'h00); send(8'h10); send(8'h00); pkt_end(snap);
      check_eq("long_eop_pulse", 32'(snap), 32'h1);
      check_counts("long_counts", 16'h0001);

      // Line error after byte1 aborts silently
      pkt_start; send(8'h2D); send(8'h00);
      rx_error = 1'b1; tick; rx_error = 1'b0; tick;
      send(8'h10); pkt_end(snap);
      check_counts("rx_error_counts", 16'h0000);
      check_eq("rx_error_token", 32'(token), 32'(exp_tok));

      // Reset in the middle of a token, then replay SETUP
      pkt_start; send(8'h2D); send(8'h00);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_pid", 32'(pid), 32'(PID_RESERVED));
      check_eq("midrst_token", 32'(token), 32'd0);
      check_eq("midrst_frame", 32'(frame_no), 32'd0);
      rx_active = 1'b0;
      tick; tick;
      check_eq("midrst_pulses", 32'({pid_valid, token_done, pid_err, crc5_err}), 32'd0);
      rst_n = 1'b1;
      tick; tick;
      pkt_start; send(8'h2D); send(8'h00); send(8'h10); pkt_end(snap);
      check_eq("replay_eop_pulse", 32'(snap), 32'h4);
      check_counts("replay_counts", 16'h0100);
      exp_tok = '{pid: PID_SETUP, addr: 7'd0, endp: 4'd0, crc5: 5'h02};
      check_eq("replay_token", 32'(token), 32'(exp_tok));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/usb_token_rx.md
Name: usb_token_rx

Overview:
- Packet-level receive stage downstream of the NRZI-decode/bit-unstuff receiver and upstream of the SIE endpoint controller.
- Consumes the received byte stream of one packet and decodes the PID byte: PID nibble plus inverted-PID check.
- For token packets (OUT/IN/SOF/SETUP), assembles addr/endp/crc5, verifies CRC5, filters on device address and emits a token_done pulse.
- For non-token packets, reports the PID and ignores the rest of the packet.

Parameters:
- None. The speed selection is already global (types::USB_FULL_SPEED) and does not affect byte-level decoding.

Ports:
- clk        in   1   system clock
- rst_n      in   1   asynchronous reset, active low
- rx_active  in   1   high from end of SYNC until EOP detected; low between packets
- rx_valid   in   1   one-cycle strobe, rx_data holds a complete byte
- rx_data    in   8   received byte, LSB = first bit on wire
- rx_error   in   1   one-cycle pulse, bit-stuff/line error in current packet
- dev_addr   in   7   assigned device address
- pid        out  4   last decoded PID (types::pid_t)
- pid_valid  out  1   one-cycle pulse, valid non-token PID received (data/handshake/special)
- token      out  -   types::token_t, fields of last accepted token; held until next accept
- frame_no   out  11  frame number of last good SOF; held
- token_done out  1   one-cycle pulse, good token for this device, or any good SOF
- pid_err    out  1   one-cycle pulse, PID check failure
- crc5_err   out  1   one-cycle pulse, CRC5 or token-length error

Behaviour:
- Reset (async, rst_n=0) values:
  - pid = RESERVED; token fields all 0; frame_no = 0.
  - All pulse outputs 0; FSM in IDLE.
- Byte layout:
  - byte0 = {pidx, pid}
  - byte1 = {endp[0], addr[6:0]}
  - byte2 = {crc5[4:0], endp[3:1]}
  - For SOF, frame_no = {byte2[2:0], byte1}.
- PID check: pidx == ~pid, else pid_err. Token class is pid[1:0] == 2'b01.
- CRC5:
  - Polynomial x^5+x^2+1, register initialised to 5'b11111.
  - Clocked over all 16 bits of byte1/byte2 in wire order (LSB first).
  - Good packet leaves residual 5'b01100; any other value gives crc5_err.
  - Processing is 8 bits per cycle on rx_valid.
- FSM states: IDLE, PID, TOK1, TOK2, TEOP, SKIP.
  - IDLE: rx_active rising -> PID.
  - PID:
    - rx_valid with bad check -> pulse pid_err, go SKIP.
    - Good token PID -> latch pid, init CRC, go TOK1.
    - Good non-token PID -> latch pid, pulse pid_valid next cycle, go SKIP.
    - rx_active falls before any byte -> IDLE, no outputs.
  - TOK1: rx_valid -> shadow-latch byte1, update CRC, go TOK2.
  - TOK2: rx_valid -> shadow-latch byte2, update CRC, go TEOP.
  - TEOP:
    - rx_active falls -> evaluate CRC residual.
    - An extra rx_valid before EOP -> length error, go SKIP.
  - TOK1/TOK2 with rx_active falling (short token) -> pulse crc5_err, go IDLE.
  - SKIP: wait for rx_active low -> IDLE. Any length error pulses crc5_err once on EOP.
- Token evaluation (cycle after rx_active falls in TEOP):
  - Bad CRC -> crc5_err.
  - Good CRC, SOF -> update frame_no, pulse token_done.
  - Good CRC, other token with addr == dev_addr -> update token, pulse token_done.
  - Good CRC, address mismatch -> no pulse, token unchanged.
- token_done latency: exactly 1 clk after rx_active deasserts.
- Shadow registers: token outputs update only on accept. Rejected or corrupt packets never disturb held values.
- rx_error in any non-IDLE state:
  - Abort to SKIP.
  - Suppress all pulses for that packet; upstream reports the error.
- rx_active rising while not IDLE (missing EOP): restart in PID state, prior packet discarded silently.
- rx_valid in IDLE: ignored.
- At most one of pid_valid/token_done/pid_err/crc5_err per packet.

Decomposition:
- The types package gains:
  - CRC5 residual constant 5'b01100.
  - Token/non-token PID class helper function.
  - FSM state enum tok_state_t.
- Sub-module usb_crc5: combinational 8-bit-parallel CRC5 next-state function (crc_in[4:0], data[7:0] -> crc_out[4:0]), reused by the transmitter.

Test Plan:
1. SETUP token, dev_addr=0, bytes 0x2D,0x00,0x10 then EOP -> token_done 1 cycle after EOP; token.pid=SETUP, addr=0, endp=0, crc5=0x02.
2. SOF, bytes 0xA5,0x00,0x10, dev_addr=5 -> token_done; frame_no=0; token fields unchanged.
3. Same SETUP bytes with dev_addr=5 -> no pulse; then byte2=0x11 with dev_addr=0 -> crc5_err only, token unchanged.
4. Byte0=0x2E (bad pidx) -> pid_err once. Byte0=0xD2 (ACK) then EOP -> pid_valid, pid=ACK, no token_done.
5. Length/abort cases, each producing the stated response:
   - 0x2D,0x00 then EOP -> crc5_err.
   - 0x2D,0x00,0x10,0x00 -> crc5_err.
   - rx_error after byte1 -> no pulses.
6. rst_n low mid-token (after byte1), release, replay scenario 1 -> outputs at reset values during reset; token_done afterwards.
